// File: rtl/uart_report_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_report_sched
// Brief    : Round-robin scheduler sharing one decimal UART printer among
//            CH_NUM producers, each with a one-entry holding slot and a
//            per-frame watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_report_sched #(
    parameter int CH_NUM    = 4,
    parameter int DATA_W    = 16,
    parameter int TO_CYCLES = 2_000_000,
    localparam int CH_W     = $clog2(CH_NUM)
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [CH_NUM-1:0]        req_valid,
    input  logic [CH_NUM*DATA_W-1:0] req_data,
    output logic [CH_NUM-1:0]        req_ready,
    output logic [CH_NUM-1:0]        drop_flag,
    input  logic                     drop_clr,
    output logic                     prn_ena,
    output logic [DATA_W-1:0]        prn_data,
    input  logic                     prn_ready,
    input  logic                     prn_done,
    output logic                     busy,
    output logic [CH_W-1:0]          cur_ch,
    output logic                     to_err
);

    localparam int WD_W = $clog2(TO_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic [CH_NUM-1:0]   r_slot_full;
    logic [DATA_W-1:0]   r_slot_data [CH_NUM];
    logic [CH_NUM-1:0]   r_drop;
    logic                r_prn_ena;
    logic [DATA_W-1:0]   r_prn_data;
    logic [CH_W-1:0]     r_cur_ch;
    logic [CH_W-1:0]     r_last_grant;
    logic [WD_W-1:0]     r_wd;
    logic                r_to_err;

    logic [CH_NUM-1:0]   w_wr;
    logic [CH_NUM-1:0]   w_rel_mask;
    logic                w_any;
    logic [CH_W-1:0]     w_grant;
    logic                w_wd_exp;

    assign w_wr       = req_valid & ~r_slot_full;
    assign w_rel_mask = (r_state == S_RELEASE) ? (CH_NUM'(1) << r_cur_ch) : '0;
    assign w_wd_exp   = (r_wd == WD_W'(TO_CYCLES - 1));

    // Descending scan so the slot closest after last_grant is assigned last and wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = CH_NUM; k >= 1; k--) begin
            logic [CH_W:0] w_sum;
            w_sum = {1'b0, r_last_grant} + (CH_W+1)'(k);
            if (w_sum >= (CH_W+1)'(CH_NUM)) begin
                w_sum = w_sum - (CH_W+1)'(CH_NUM);
            end
            if (r_slot_full[w_sum[CH_W-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_sum[CH_W-1:0];
            end
        end
    end

    // A slot being released is full, so a write can never collide with its clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_slot_full <= '0;
            r_drop      <= '0;
        end else begin
            r_slot_full <= (r_slot_full | w_wr) & ~w_rel_mask;
            r_drop      <= (r_drop & ~{CH_NUM{drop_clr}}) | (req_valid & r_slot_full);
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_slot
        always_ff @(posedge sys_clk) begin
            if (w_wr[g]) begin
                r_slot_data[g] <= req_data[g*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_prn_ena    <= 1'b0;
            r_prn_data   <= '0;
            r_cur_ch     <= '0;
            r_last_grant <= CH_W'(CH_NUM - 1);
            r_wd         <= '0;
            r_to_err     <= 1'b0;
        end else begin
            r_to_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wd <= '0;
                    if (w_any) begin
                        r_prn_data <= r_slot_data[w_grant];
                        r_cur_ch   <= w_grant;
                        r_prn_ena  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_wd <= r_wd + WD_W'(1);
                    if (prn_ready) begin
                        r_prn_ena <= 1'b0;
                        r_state   <= S_BUSY;
                    end else if (w_wd_exp) begin
                        r_prn_ena <= 1'b0;
                        r_to_err  <= 1'b1;
                        r_state   <= S_RELEASE;
                    end
                end
                S_BUSY: begin
                    r_wd <= r_wd + WD_W'(1);
                    if (prn_done) begin
                        r_state <= S_RELEASE;
                    end else if (w_wd_exp) begin
                        r_to_err <= 1'b1;
                        r_state  <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_last_grant <= r_cur_ch;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = ~r_slot_full;
    assign drop_flag = r_drop;
    assign prn_ena   = r_prn_ena;
    assign prn_data  = r_prn_data;
    assign busy      = (r_state != S_IDLE);
    assign cur_ch    = r_cur_ch;
    assign to_err    = r_to_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_report_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_report_sched
// Brief    : Scoreboard bench for uart_report_sched with a printer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_report_sched;

    localparam int CH_NUM    = 4;
    localparam int DATA_W    = 16;
    localparam int TO_CYCLES = 700;
    localparam int M_NORMAL    = 0;
    localparam int M_HANG_RDY  = 1;
    localparam int M_HANG_DONE = 2;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst;
    logic [CH_NUM-1:0]        req_valid;
    logic [CH_NUM*DATA_W-1:0] req_data;
    logic [CH_NUM-1:0]        req_ready;
    logic [CH_NUM-1:0]        drop_flag;
    logic                     drop_clr;
    logic                     prn_ena;
    logic [DATA_W-1:0]        prn_data;
    logic                     prn_ready;
    logic                     prn_done;
    logic                     busy;
    logic [1:0]               cur_ch;
    logic                     to_err;

    uart_report_sched #(
        .CH_NUM   (CH_NUM),
        .DATA_W   (DATA_W),
        .TO_CYCLES(TO_CYCLES)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .drop_flag(drop_flag),
        .drop_clr (drop_clr),
        .prn_ena  (prn_ena),
        .prn_data (prn_data),
        .prn_ready(prn_ready),
        .prn_done (prn_done),
        .busy     (busy),
        .cur_ch   (cur_ch),
        .to_err   (to_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
        int          rd;
        int          dd;
        int          mode;
        int          exp_ena;
        int          exp_err;
    } frame_t;

    frame_t      exp_q[$];
    frame_t      plan_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  m_last;
    bit          rst_abort = 1'b0;
    logic [15:0] p_d  [4];
    int          p_rd [4];
    int          p_dd [4];
    int          p_md [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: grant order is every offered channel, cyclically after the last served one.
    task automatic issue(input logic [3:0] mask);
        frame_t     f;
        logic [1:0] last;
        last = m_last;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] ch;
            ch = m_last + 2'(k);
            if (mask[ch]) begin
                f.ch      = ch;
                f.data    = p_d[ch];
                f.rd      = p_rd[ch];
                f.dd      = p_dd[ch];
                f.mode    = p_md[ch];
                f.exp_err = (f.mode != M_NORMAL || f.rd + f.dd > TO_CYCLES) ? 1 : 0;
                f.exp_ena = (f.mode == M_HANG_RDY) ? TO_CYCLES : f.rd;
                exp_q.push_back(f);
                plan_q.push_back(f);
                last = ch;
            end
        end
        m_last = last;
        @(negedge sys_clk);
        req_valid = mask;
        for (int c = 0; c < 4; c++) req_data[c*16 +: 16] = p_d[c];
        @(negedge sys_clk);
        req_valid = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!(busy == 1'b0 && req_ready == 4'hf && exp_q.size() == 0) && n < budget);
        check(name, (busy == 1'b0 && req_ready == 4'hf && exp_q.size() == 0) ? 1 : 0, 1);
    endtask

    task automatic set_plan(input int ch, input logic [15:0] d, input int rd, input int dd, input int md);
        p_d[ch] = d; p_rd[ch] = rd; p_dd[ch] = dd; p_md[ch] = md;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prn_ena"},   int'(prn_ena),   0);
        check({tag, "_prn_data"},  int'(prn_data),  0);
        check({tag, "_cur_ch"},    int'(cur_ch),    0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_to_err"},    int'(to_err),    0);
        check({tag, "_drop_flag"}, int'(drop_flag), 0);
        check({tag, "_req_ready"}, int'(req_ready), 15);
    endtask

    // Printer model: follows the plan attached to each granted frame.
    initial begin
        frame_t p;
        prn_ready = 1'b0;
        prn_done  = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (prn_ena && !sys_rst) begin
                if (plan_q.size() > 0) p = plan_q.pop_front();
                else p.mode = M_HANG_RDY;
                if (p.mode != M_HANG_RDY) begin
                    repeat (p.rd - 1) @(negedge sys_clk);
                    prn_ready = 1'b1;
                    @(negedge sys_clk);
                    prn_ready = 1'b0;
                    if (p.mode == M_NORMAL) begin
                        repeat (p.dd - 1) @(negedge sys_clk);
                        prn_done = 1'b1;
                        @(negedge sys_clk);
                        prn_done = 1'b0;
                    end
                end
                while (busy) @(negedge sys_clk);
            end
        end
    end

    // Monitor: pops the expected frame on each grant and checks it through release.
    initial begin
        frame_t cur;
        bit     prev_busy = 1'b0;
        bit     in_frame  = 1'b0;
        bit     unstable;
        int     ena_cnt, err_cnt;
        forever begin
            @(negedge sys_clk);
            if (busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant ch=%0d data=%0d required=no grant", cur_ch, prn_data);
                    in_frame = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    in_frame = 1'b1;
                    check("grant_ch", int'(cur_ch), int'(cur.ch));
                    check("grant_data", int'(prn_data), int'(cur.data));
                    ena_cnt  = 0;
                    err_cnt  = 0;
                    unstable = 1'b0;
                end
            end
            if (busy && in_frame) begin
                if (prn_ena) ena_cnt++;
                if (prn_data !== cur.data || cur_ch !== cur.ch) unstable = 1'b1;
            end
            if (to_err) err_cnt++;
            if (!busy && prev_busy && in_frame) begin
                in_frame = 1'b0;
                if (!rst_abort) begin
                    check("ena_cycles", ena_cnt, cur.exp_ena);
                    check("to_err_pulses", err_cnt, cur.exp_err);
                    check("slot_freed", int'(req_ready[cur.ch]), 1);
                    check("data_stable", int'(unstable), 0);
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        sys_rst   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        drop_clr  = 1'b0;
        m_last    = 2'd3;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_reset_outputs("reset");

        // Spurious printer pulses while idle must be ignored.
        prn_ready = 1'b1; prn_done = 1'b1;
        @(negedge sys_clk);
        prn_ready = 1'b0; prn_done = 1'b0;
        @(negedge sys_clk);
        check("spurious_busy", int'(busy), 0);
        check("spurious_to_err", int'(to_err), 0);

        set_plan(0, 16'd12345, 3, 600, M_NORMAL);
        issue(4'b0001);
        wait_idle("single_idle", 2000);

        // Overflow on ch2 while its slot is held by a long frame.
        set_plan(2, 16'($urandom), 2, 60, M_NORMAL);
        issue(4'b0100);
        check("ovf_ready_low", int'(req_ready[2]), 0);
        req_valid = 4'b0100;
        req_data[2*16 +: 16] = 16'd999;
        @(negedge sys_clk);
        req_valid = '0;
        check("ovf_drop_set", int'(drop_flag), 4);
        repeat (3) @(negedge sys_clk);
        check("ovf_drop_sticky", int'(drop_flag), 4);
        req_valid = 4'b0100;
        drop_clr  = 1'b1;
        @(negedge sys_clk);
        req_valid = '0;
        drop_clr  = 1'b0;
        check("ovf_set_wins", int'(drop_flag), 4);
        drop_clr = 1'b1;
        @(negedge sys_clk);
        drop_clr = 1'b0;
        check("ovf_cleared", int'(drop_flag), 0);
        wait_idle("ovf_idle", 2000);

        // Watchdog: ch0 never gets ready, ch1 must be served next.
        set_plan(0, 16'd111, 1, 1, M_HANG_RDY);
        set_plan(1, 16'd222, 2, 5, M_NORMAL);
        issue(4'b0011);
        wait_idle("wd_ready_idle", 3000);
        set_plan(3, 16'd333, 4, 1, M_HANG_DONE);
        issue(4'b1000);
        wait_idle("wd_done_idle", 3000);

        // Done exactly on the expiry cycle, then one cycle too late.
        set_plan(1, 16'd444, 3, TO_CYCLES - 3, M_NORMAL);
        issue(4'b0010);
        wait_idle("boundary_idle", 3000);
        set_plan(2, 16'd555, 3, TO_CYCLES - 2, M_NORMAL);
        issue(4'b0100);
        wait_idle("late_idle", 3000);
        check("late_no_drop", int'(drop_flag), 0);

        for (int r = 0; r < 40; r++) begin
            logic [3:0] mask;
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++) begin
                int sel, rd;
                sel = $urandom_range(0, 19);
                rd  = $urandom_range(1, 5);
                if (sel == 0)      set_plan(c, 16'($urandom), rd, 1, M_HANG_RDY);
                else if (sel == 1) set_plan(c, 16'($urandom), rd, 1, M_HANG_DONE);
                else if (sel == 2) set_plan(c, 16'($urandom), rd, TO_CYCLES - rd, M_NORMAL);
                else               set_plan(c, 16'($urandom), rd, $urandom_range(1, 30), M_NORMAL);
            end
            issue(mask);
            wait_idle("rand_idle", 4 * TO_CYCLES + 500);
        end
        check("rand_no_drop", int'(drop_flag), 0);

        // Reset during BUSY, with a second slot still waiting.
        set_plan(0, 16'd777, 2, 1, M_HANG_DONE);
        set_plan(3, 16'd888, 2, 1, M_HANG_DONE);
        issue(4'b1001);
        begin
            int n = 0;
            while (!busy && n < 20) begin
                @(negedge sys_clk);
                n++;
            end
        end
        repeat (10) @(negedge sys_clk);
        rst_abort = 1'b1;
        sys_rst   = 1'b1;
        @(negedge sys_clk);
        check_reset_outputs("midrst");
        sys_rst = 1'b0;
        exp_q.delete();
        plan_q.delete();
        m_last = 2'd3;
        @(negedge sys_clk);
        rst_abort = 1'b0;

        // Fairness after reset: order 1,2,3,4 then the ch0 reload 5.
        for (int c = 0; c < 4; c++) set_plan(c, 16'(c + 1), 2, 10, M_NORMAL);
        issue(4'b1111);
        begin
            int n = 0;
            while (!req_ready[0] && n < 500) begin
                @(negedge sys_clk);
                n++;
            end
            check("fair_ch0_freed", int'(req_ready[0]), 1);
        end
        set_plan(0, 16'd5, 2, 10, M_NORMAL);
        issue(4'b0001);
        wait_idle("fair_idle", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
